// File: rtl/dmem_map_pkg.sv
// rtl/dmem_map_pkg.sv - address map, register offsets and STATUS layout for dmem_responder
package dmem_map_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;

  localparam logic [31:0] OFF_TXDATA = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd1;
  localparam logic [31:0] OFF_CYCLES = 32'd2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 3;
  localparam int STAT_COUNT_W   = 5;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_RAM    = 3'd1,
    SEL_TXDATA = 3'd2,
    SEL_STATUS = 3'd3,
    SEL_CYCLES = 3'd4
  } dmem_sel_e;

  // RAM and the I/O window can never overlap while depth stays below base.
  function automatic dmem_sel_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] depth,
                                            input logic [31:0] base);
    dmem_sel_e sel;
    sel = SEL_NONE;
    if (addr < depth)                     sel = SEL_RAM;
    else if (addr == base + OFF_TXDATA)   sel = SEL_TXDATA;
    else if (addr == base + OFF_STATUS)   sel = SEL_STATUS;
    else if (addr == base + OFF_CYCLES)   sel = SEL_CYCLES;
    return sel;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - first-word-fall-through console TX FIFO, falling-edge clocked
module tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          drop
);

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign head = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(negedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus TX FIFO / cycle counter I/O window
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int          DEPTH      = 4096,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = dmem_map_pkg::MMIO_BASE,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        overflow
);

  logic [31:0] ram [DEPTH];
  logic [31:0] cycles;
  logic [31:0] rd_word;
  logic [31:0] status_word;
  logic [4:0]  count5;
  dmem_sel_e   sel;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_drop;
  logic [CW-1:0] fifo_count;

  assign sel       = decode_addr(address_dmem, 32'(DEPTH), MMIO_BASE);
  assign fifo_push = wren && (sel == SEL_TXDATA);
  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (data),
    .pop       (fifo_pop),
    .head      (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // STATUS shows the FIFO as it stands before this edge's push/pop.
  always_comb begin
    status_word = '0;
    count5      = 5'(fifo_count);
    status_word[STAT_EMPTY]                            = fifo_empty;
    status_word[STAT_FULL]                             = fifo_full;
    status_word[STAT_OVERFLOW]                         = overflow;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]        = count5;
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_RAM:    rd_word = ram[address_dmem[ADDR_W-1:0]];
      SEL_STATUS: rd_word = status_word;
      SEL_CYCLES: rd_word = cycles;
      default:    rd_word = '0;
    endcase
  end

  // RAM contents survive reset; reads return the pre-write word.
  always_ff @(negedge clock) begin
    if (wren && (sel == SEL_RAM)) ram[address_dmem[ADDR_W-1:0]] <= data;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) q_dmem <= '0;
    else       q_dmem <= rd_word;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset)                          cycles <= '0;
    else if (wren && sel == SEL_CYCLES) cycles <= data;
    else                                cycles <= cycles + 32'd1;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset)                          overflow <= 1'b0;
    else if (wren && sel == SEL_STATUS) overflow <= 1'b0;
    else if (fifo_drop)                 overflow <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] TX  = 32'hFFFF_FF00;
  localparam logic [31:0] ST  = 32'hFFFF_FF01;
  localparam logic [31:0] CY  = 32'hFFFF_FF02;
  localparam logic [31:0] UNM = 32'h0000_2000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        overflow;

  int errors;
  int checks;
  int rcv;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access, let the falling edge happen, settle just after it.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data         = d;
    wren         = w;
    @(negedge clock);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rcv    = 0;
    reset = 1'b0; address_dmem = UNM; data = '0; wren = 1'b0; out_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_q", q_dmem, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    #4 reset = 1'b0;

    // RAM write/read and read-during-write
    cycle(32'd5, 32'hDEAD_BEEF, 1'b1);
    cycle(32'd5, 32'd0, 1'b0);
    check("ram_rd", q_dmem, 32'hDEAD_BEEF);
    cycle(32'd5, 32'd1234, 1'b1);
    check("ram_rdw_old", q_dmem, 32'hDEAD_BEEF);
    cycle(32'd5, 32'd0, 1'b0);
    check("ram_rd_new", q_dmem, 32'd1234);

    // Fill FIFO, overflow, clear
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) cycle(TX, 32'(i), 1'b1);
    cycle(ST, 32'd0, 1'b0);
    check("st_full", q_dmem, 32'h42);
    check("head_1", out_data, 32'd1);
    cycle(TX, 32'd99, 1'b1);
    check("tx_rd_zero", q_dmem, 32'd0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    cycle(ST, 32'd0, 1'b0);
    check("st_ovf", q_dmem, 32'h46);
    cycle(ST, 32'd0, 1'b1);
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    cycle(ST, 32'd0, 1'b0);
    check("st_after_clr", q_dmem, 32'h42);

    // Push while full with simultaneous pop, then drain
    out_ready = 1'b1;
    cycle(TX, 32'd9, 1'b1);
    out_ready = 1'b0;
    cycle(ST, 32'd0, 1'b0);
    check("st_full_pushpop", q_dmem, 32'h42);
    check("ovf_pushpop", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data", out_data, 32'(k));
      cycle(UNM, 32'd0, 1'b0);
    end
    out_ready = 1'b0;
    cycle(ST, 32'd0, 1'b0);
    check("st_empty", q_dmem, 32'h01);
    check("empty_valid", {31'd0, out_valid}, 32'd0);

    // Streaming with toggled ready; pointers wrap
    for (int i = 0; i < 48 && rcv < 16; i++) begin
      out_ready = i[0];
      if (out_valid && out_ready) begin
        check("stream_data", out_data, 32'(100 + rcv));
        rcv++;
      end
      if (i < 16) cycle(TX, 32'(100 + i), 1'b1);
      else        cycle(UNM, 32'd0, 1'b0);
    end
    out_ready = 1'b0;
    check("stream_count", 32'(rcv), 32'd16);
    check("stream_ovf", {31'd0, overflow}, 32'd0);
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Cycle counter load and wrap
    cycle(CY, 32'hFFFF_FFFE, 1'b1);
    cycle(UNM, 32'd0, 1'b0);
    cycle(CY, 32'd0, 1'b0);
    check("cyc_ff", q_dmem, 32'hFFFF_FFFF);
    cycle(CY, 32'd0, 1'b0);
    check("cyc_wrap", q_dmem, 32'd0);

    // Unmapped access must not alias RAM
    cycle(32'd0, 32'h0000_AAAA, 1'b1);
    cycle(UNM, 32'h0000_5555, 1'b1);
    check("unm_wr_q", q_dmem, 32'd0);
    cycle(UNM, 32'd0, 1'b0);
    check("unm_rd_q", q_dmem, 32'd0);
    cycle(32'd0, 32'd0, 1'b0);
    check("unm_no_alias", q_dmem, 32'h0000_AAAA);
    cycle(ST, 32'd0, 1'b0);
    check("unm_status", q_dmem, 32'h01);

    // Asynchronous reset with FIFO holding data and overflow set
    for (int i = 0; i < 9; i++) cycle(TX, 32'(50 + i), 1'b1);
    cycle(ST, 32'd0, 1'b0);
    check("pre_rst_status", q_dmem, 32'h46);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_q", q_dmem, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    check("arst_data", out_data, 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b0;
    cycle(TX, 32'd77, 1'b1);
    check("post_rst_head", out_data, 32'd77);
    cycle(ST, 32'd0, 1'b0);
    check("post_rst_status", q_dmem, 32'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory port: it answers `address_dmem`/`data`/`wren` and returns `q_dmem`.
- It contains a word-addressed data RAM and a small memory-mapped I/O window.
- The I/O window provides a console transmit FIFO, drained over a valid/ready stream, plus a free-running cycle counter.
- It sits in the wrapper beside the processor, in place of a bare dmem.

Parameters:
- DEPTH, 4096, number of 32-bit RAM words; RAM occupies word addresses 0..DEPTH-1.
- ADDR_W, 12, log2(DEPTH); RAM index is `address_dmem[ADDR_W-1:0]`.
- FIFO_DEPTH, 8, TX FIFO entries (power of two).
- MMIO_BASE, 32'hFFFF_FF00, base word address of the I/O window.

Ports:
- clock  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- address_dmem  in  32  word address from the processor.
- data  in  32  write data.
- wren  in  1  write enable.
- q_dmem  out  32  registered read data.
- out_valid  out  1  TX FIFO head is valid.
- out_data  out  32  TX FIFO head word.
- out_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Timing:
  - One clock; reset is asynchronous and active-high.
  - All state (RAM, `q_dmem`, FIFO, counter, flags) updates on the falling edge of `clock`. This keeps `q_dmem` stable for the processor's next rising edge.
- Read:
  - At each falling edge, `q_dmem` is loaded with the word at `address_dmem` sampled at that edge.
  - Read-during-write to the same RAM word returns the OLD word.
- Address decode, evaluated every falling edge:
  - addr < DEPTH: RAM. If `wren`, RAM[addr] <= data.
  - addr == MMIO_BASE+0 (TXDATA):
    - write pushes `data` into the FIFO;
    - read returns 0.
  - addr == MMIO_BASE+1 (STATUS):
    - read returns {24'b0, count[4:0], overflow, full, empty}; count = entries held, 0..FIFO_DEPTH;
    - any write clears `overflow`.
  - addr == MMIO_BASE+2 (CYCLES): read returns the counter; a write loads the counter with `data`.
  - Any other address: read returns 0; write ignored, with no side effects.
- Cycle counter:
  - 32-bit, increments every falling edge and wraps FFFFFFFF->0.
  - A CYCLES write takes priority over the increment on that edge.
- TX FIFO (first-word-fall-through):
  - `out_valid` = !empty; `out_data` = head entry, and is 0 when empty.
  - Pop occurs on a falling edge when out_valid && out_ready.
  - Push when not full: accepted.
  - Push when full and a pop occurs on the same edge: accepted; count unchanged.
  - Push when full with no pop: dropped; `overflow` <= 1.
  - A push and a STATUS-write clear cannot coincide, because the addresses differ.
  - Pointers are log2(FIFO_DEPTH)+1 bits. empty = pointers equal; full = MSBs differ and the rest are equal. Pointers wrap naturally.
- Reset (asynchronous):
  - Outputs: `q_dmem`=0, out_valid=0, out_data=0, overflow=0.
  - FIFO pointers = 0; counter = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-handshake discards all FIFO entries. The first falling edge after deassertion behaves as a normal cycle.
- STATUS reads reflect the state before the current edge's push/pop.

Decomposition:
- Shared package `dmem_map_pkg`: MMIO_BASE, register offsets (TXDATA=0, STATUS=1, CYCLES=2), and the STATUS bit positions.
- Sub-module `tx_fifo`:
  - Ports: clock, reset, push, push_data, pop, head, empty, full, count, drop.
  - Parameter: FIFO_DEPTH.
  - Falling-edge, async-reset behaviour as above.
- The top level holds the RAM, decode, read mux, counter and overflow flag.

Test Plan:
- Write 32'hDEADBEEF to addr 5, then read addr 5 -> `q_dmem`=DEADBEEF after the next falling edge. Read addr 5 during a write of 1234 -> old value DEADBEEF, then 1234 on the following read.
- out_ready=0; push 1..8 to TXDATA -> STATUS reads count=8, full=1, overflow=0. Push a 9th word -> dropped, overflow=1. Write STATUS -> overflow=0.
- FIFO holds 8 entries, out_ready=1, push 9 on the same edge -> accepted, count stays 8. Drain order is 2,3,...,9; the final STATUS read shows empty=1.
- Push 16 words while continuously draining with out_ready toggled 1,0,1,0 -> all 16 are received in order, with no loss and correct pointer wrap.
- Write FFFFFFFE to CYCLES -> reads on later falling edges give FFFFFFFF, then 00000000 (wrap).
- Read/write 32'h0000_2000 (unmapped, DEPTH=4096) -> `q_dmem`=0 and no state change. Assert reset while out_valid=1 -> out_valid=0, q_dmem=0, overflow=0 immediately, with no clock edge required.
